voice_allocator: RTL
====================

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 SHALL have parameter NUM_BITS_IN, default 18, width of the note frequency control word.
REQ-002 SHALL have parameter NUM_CHANNELS, default 16, number of voices; only 8 and 16 are supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port ev_valid, input, 1, MIDI event present.
REQ-006 SHALL have port ev_ready, output, 1, event accepted when ev_valid && ev_ready.
REQ-007 SHALL have port ev_note_on, input, 1: 1 = note-on, 0 = note-off.
REQ-008 SHALL have port ev_key, input, 7, MIDI key number 0-127.
REQ-009 SHALL have port ev_velocity, input, 7, MIDI velocity.
REQ-010 SHALL have port panic, input, 1, all-notes-off request.
REQ-011 SHALL have port available, input, NUM_CHANNELS, per-channel envelope-idle flags from the downstream voice stage.
REQ-012 SHALL have port reg_en, output, NUM_CHANNELS, one-hot single-cycle voice load strobe.
REQ-013 SHALL have port note_en, output, NUM_CHANNELS, per-channel key-held level (gate).
REQ-014 SHALL have port note_in, output, NUM_BITS_IN, frequency control word for the strobed channel.
REQ-015 SHALL have port velocity_out, output, 32*NUM_CHANNELS, per-channel 32-bit velocity words; channel j occupies bits [32*j+31:32*j].
REQ-016 SHALL have port dropped, output, 1, single-cycle pulse when a note-on finds no free voice.

Function
REQ-017 SHALL implement FSM IDLE -> LOOKUP -> WRITE -> IDLE; ev_ready = 1 only in IDLE.
REQ-018 Accept at cycle T SHALL register event fields and move to LOOKUP; at T+1, in LOOKUP, SHALL read the key ROM and resolve the target channel; at T+2, in WRITE, SHALL apply the effect; ev_ready SHALL be high again at T+3.
REQ-019 A note-on with ev_velocity = 0 SHALL be treated as note-off.
REQ-020 Note-on, key already held (note_en[c]=1 and key_reg[c]=ev_key): SHALL retrigger channel c (lowest such c) with new velocity.
REQ-021 Note-on, otherwise: SHALL choose the lowest-index channel with available=1 and note_en=0.
REQ-022 Note-on with a channel chosen: in WRITE, SHALL pulse reg_en[c] for exactly one cycle, drive note_in = ROM word, set note_en[c]=1, key_reg[c]=ev_key, and velocity slice c = {ev_velocity, 25'b0}.
REQ-023 Note-on with no channel found: in WRITE, SHALL pulse dropped, leave reg_en at 0, and leave all state unchanged.
REQ-024 Note-off: in WRITE, SHALL clear note_en[c] for the lowest c with note_en[c]=1 and key_reg[c]=ev_key; no match SHALL be ignored; reg_en SHALL never pulse for note-off.
REQ-025 note_in and velocity slices SHALL hold their values between writes.
REQ-026 panic SHALL clear all note_en on the next edge, return the FSM to IDLE, discard any in-flight event with no reg_en pulse, and take priority over WRITE in the same cycle.
REQ-027 The key ROM SHALL hold 128 entries of NUM_BITS_IN bits with equal-tempered increments; entries SHALL saturate at the all-ones value, never wrap.

Reset
REQ-028 During rst: ev_ready=0, reg_en=0, note_en=0, note_in=0, velocity_out=0, dropped=0, key registers=0, FSM=IDLE.
REQ-029 ev_ready SHALL be 1 in the first cycle after rst deasserts; an rst mid-event SHALL abandon the event with no output pulse.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding, the velocity shift (25), and the ROM depth (128).
REQ-031 The key ROM SHALL be a sub-module key_to_fcw with a registered read of 1-cycle latency.

Verification
REQ-032 After reset, note-on key 69 vel 100: reg_en=0x0001 at T+2, note_in=ROM[69], note_en[0]=1, velocity slice 0=0xC8000000, ev_ready=1 at T+3.
REQ-033 Note-on for keys 60, 64, 67 with all channels available: channels 0, 1, 2 are loaded in order; note-off 64 clears note_en[1] only.
REQ-034 Fill all NUM_CHANNELS voices, then send a 17th note-on: dropped pulses once, reg_en stays 0, note_en is unchanged.
REQ-035 Note-on key 60 vel 0 while key 60 is held on channel 3: note_en[3]=0 and no reg_en pulse.
REQ-036 Retrigger key 60 vel 50 while held on channel 0: reg_en[0] pulses and velocity slice 0=0x64000000.
REQ-037 panic asserted in the LOOKUP cycle of a note-on: no reg_en pulse, note_en=0 on the next cycle, ev_ready=1; the same case with rst gives the reset values.

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: FSM encoding, field widths and
// the equal-tempered key-to-frequency-control-word table generator.
package voice_allocator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_WRITE  = 2'd2
  } state_t;

  localparam int KEY_W          = 7;
  localparam int VEL_W          = 7;
  localparam int VEL_SHIFT      = 25;
  localparam int ROM_DEPTH      = 128;
  localparam int FCW_FRAC_SHIFT = 6;

  // 2^(n/12) scaled by 32768, rounded; one octave of semitone ratios.
  function automatic logic [15:0] semitone_ratio(input int n);
    logic [15:0] r;
    case (n)
      0:       r = 16'd32768;
      1:       r = 16'd34716;
      2:       r = 16'd36781;
      3:       r = 16'd38968;
      4:       r = 16'd41285;
      5:       r = 16'd43740;
      6:       r = 16'd46341;
      7:       r = 16'd49097;
      8:       r = 16'd52016;
      9:       r = 16'd55109;
      10:      r = 16'd58386;
      11:      r = 16'd61858;
      default: r = 16'd32768;
    endcase
    return r;
  endfunction

  // Unsaturated control word: semitone ratio doubled once per octave.
  function automatic logic [63:0] key_fcw_raw(input int key);
    logic [63:0] r;
    r = 64'(semitone_ratio(key % 12));
    return (r << (key / 12)) >> FCW_FRAC_SHIFT;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// MIDI event handshake between the event source and the voice allocator.
interface voice_allocator_if;
  import voice_allocator_pkg::*;

  logic             ev_valid;
  logic             ev_ready;
  logic             ev_note_on;
  logic [KEY_W-1:0] ev_key;
  logic [VEL_W-1:0] ev_velocity;

  modport master (
    output ev_valid,
    output ev_note_on,
    output ev_key,
    output ev_velocity,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_note_on,
    input  ev_key,
    input  ev_velocity,
    output ev_ready
  );

endinterface

// File: rtl/voice_allocator_key_to_fcw.sv
// Key-number to frequency-control-word ROM with a single registered read stage.
module key_to_fcw
  import voice_allocator_pkg::*;
#(
  parameter int NUM_BITS_IN = 18
) (
  input  logic                   clk,
  input  logic [KEY_W-1:0]       key,
  output logic [NUM_BITS_IN-1:0] fcw
);

  logic [NUM_BITS_IN-1:0] rom [ROM_DEPTH];

  // High keys clip to all-ones instead of wrapping to a low pitch.
  function automatic logic [NUM_BITS_IN-1:0] sat_fcw(input logic [63:0] raw);
    logic [63:0] lim;
    lim = (64'd1 << NUM_BITS_IN) - 64'd1;
    return (raw > lim) ? NUM_BITS_IN'(lim) : NUM_BITS_IN'(raw);
  endfunction

  for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
    assign rom[k] = sat_fcw(key_fcw_raw(k));
  end

  always_ff @(posedge clk) begin
    fcw <= rom[key];
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto voice channels,
// retriggering held keys, filling the lowest free voice, and dropping on overflow.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_BITS_IN  = 18,
  parameter int NUM_CHANNELS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  voice_allocator_if.slave          ev,
  input  logic                      panic,
  input  logic [NUM_CHANNELS-1:0]   available,
  output logic [NUM_CHANNELS-1:0]   reg_en,
  output logic [NUM_CHANNELS-1:0]   note_en,
  output logic [NUM_BITS_IN-1:0]    note_in,
  output logic [32*NUM_CHANNELS-1:0] velocity_out,
  output logic                      dropped
);

  localparam int CH_W = $clog2(NUM_CHANNELS);

  state_t state, state_nxt;

  logic             accept;
  logic             write_go;
  logic             is_on_p0;
  logic [KEY_W-1:0] key_p0;
  logic [VEL_W-1:0] vel_p0;
  logic             found_p1;
  logic [CH_W-1:0]  ch_p1;

  logic             hit_found, free_found;
  logic [CH_W-1:0]  hit_ch, free_ch;

  logic [KEY_W-1:0]       key_reg [NUM_CHANNELS];
  logic [NUM_BITS_IN-1:0] fcw_p1;
  logic [NUM_BITS_IN-1:0] note_hold;

  assign ev.ev_ready = (state == ST_IDLE) && !rst && !panic;
  assign accept      = ev.ev_valid && ev.ev_ready;

  always_ff @(posedge clk) begin
    if (rst || panic) state <= ST_IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    write_go  = 1'b0;
    reg_en    = '0;
    dropped   = 1'b0;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_LOOKUP;
      ST_LOOKUP: state_nxt = ST_WRITE;
      ST_WRITE:  begin
        state_nxt = ST_IDLE;
        write_go  = !rst && !panic;
      end
      default:   state_nxt = ST_IDLE;
    endcase
    if (write_go && is_on_p0) begin
      if (found_p1) reg_en[ch_p1] = 1'b1;
      else          dropped       = 1'b1;
    end
  end

  // Stage p0: capture the accepted event; zero velocity note-on means note-off.
  always_ff @(posedge clk) begin
    if (accept) begin
      is_on_p0 <= ev.ev_note_on && (ev.ev_velocity != '0);
      key_p0   <= ev.ev_key;
      vel_p0   <= ev.ev_velocity;
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_found  = 1'b0;
    hit_ch     = '0;
    free_found = 1'b0;
    free_ch    = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (note_en[i] && (key_reg[i] == key_p0)) begin
        hit_found = 1'b1;
        hit_ch    = CH_W'(i);
      end
      if (available[i] && !note_en[i]) begin
        free_found = 1'b1;
        free_ch    = CH_W'(i);
      end
    end
  end

  // Stage p1: resolve target channel while the ROM read is in flight.
  always_ff @(posedge clk) begin
    if (state == ST_LOOKUP) begin
      if (is_on_p0 && !hit_found) begin
        found_p1 <= free_found;
        ch_p1    <= free_ch;
      end else begin
        found_p1 <= hit_found;
        ch_p1    <= hit_ch;
      end
    end
  end

  key_to_fcw #(
    .NUM_BITS_IN (NUM_BITS_IN)
  ) u_key_to_fcw (
    .clk (clk),
    .key (key_p0),
    .fcw (fcw_p1)
  );

  // Stage p2: commit the voice update at the end of the write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      note_en      <= '0;
      note_hold    <= '0;
      velocity_out <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) key_reg[i] <= '0;
    end else if (panic) begin
      note_en <= '0;
    end else if (write_go && found_p1) begin
      if (is_on_p0) begin
        note_en[ch_p1]                <= 1'b1;
        key_reg[ch_p1]                <= key_p0;
        velocity_out[32*ch_p1 +: 32]  <= {vel_p0, {VEL_SHIFT{1'b0}}};
        note_hold                     <= fcw_p1;
      end else begin
        note_en[ch_p1] <= 1'b0;
      end
    end
  end

  // The fresh ROM word is presented alongside the load strobe, then held.
  assign note_in = (reg_en != '0) ? fcw_p1 : note_hold;

endmodule
